// File: rtl/cobra_loader_pkg.sv
// cobra_loader_pkg: loader state encoding and stream framing constants (CHK state only with LOADER_CHECKSUM_EN)
package cobra_loader_pkg;
  localparam int HDR_BYTES = 2;
  localparam int WORD_BYTES = 4;
  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR
`ifdef LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;
endpackage

// File: rtl/cobra_loader_wordasm.sv
// cobra_loader_wordasm: shifts bytes into a little-endian word and counts the byte position
module cobra_loader_wordasm
  import cobra_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        shift_en,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  cnt
);
  // new bytes enter at the top so the first of every four ends up in bits [7:0]
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      word <= {byte_in, word[31:8]};
      cnt  <= cnt + 2'(HDR_BYTES - 1);
    end
endmodule

// File: rtl/cobra_prog_loader.sv
// cobra_prog_loader: byte-stream program loader for CYBERcobra; LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module cobra_prog_loader
  import cobra_loader_pkg::*;
#(
  parameter int unsigned WORDS_MAX = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        cpu_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
  localparam int KW = $clog2(WORDS_MAX + 1);
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, nxt;
  logic [KW-1:0] k, len;
  logic [GW-1:0] gap;
  logic [31:0] word;
  logic [1:0] cnt;
  logic [15:0] n;
  logic load, acc, restart, tmo, last, word_full;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
  logic [7:0] chk;
  assign load = state inside {LEN_LO, LEN_HI, DATA, CHK};
`else
  localparam state_t FIN = DONE;
  assign load = state inside {LEN_LO, LEN_HI, DATA};
`endif
  assign acc = load & byte_valid_i;
  assign restart = start_i & (state inside {IDLE, DONE, ERR});
  assign tmo = load & ~acc & (gap == GW'(TIMEOUT_CYCLES - 1));
  assign last = (k + KW'(1)) == len;
  assign word_full = (state == DATA) & acc & (cnt == 2'(WORD_BYTES - 1));
  assign n = {byte_i, word[31:24]};
  assign byte_ready_o = load;
  assign mem_we_o = state == WRITE;
  assign mem_wdata_o = word;
  assign busy_o = load | (state == WRITE);
  assign cpu_rst_o = state != DONE;
  assign done_o = state == DONE;
  assign err_o = state == ERR;

  cobra_loader_wordasm u_asm (
    .clk(clk_i),
    .rstn(rstn_i),
    .shift_en(acc),
    .clr(restart | ((state == LEN_HI) & acc)),
    .byte_in(byte_i),
    .word(word),
    .cnt(cnt)
  );

  // state register; reset aborts any load in progress
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) state <= IDLE;
    else state <= nxt;

  // next state: restart and idle timeout override the normal stream sequencing
  always_comb begin
    nxt = state;
    if (restart) nxt = LEN_LO;
    else if (tmo) nxt = ERR;
    else
      case (state)
        LEN_LO: if (acc) nxt = LEN_HI;
        LEN_HI: if (acc) nxt = n == 16'd0 ? FIN : 32'(n) > WORDS_MAX ? ERR : DATA;
        DATA:   if (word_full) nxt = WRITE;
        WRITE:  nxt = last ? FIN : DATA;
`ifdef LOADER_CHECKSUM_EN
        CHK:    if (acc) nxt = byte_i == chk ? DONE : ERR;
`endif
        default: ;
      endcase
  end

  // word index, length, gap counter and write address bookkeeping
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      k <= '0;
      len <= '0;
      gap <= '0;
      mem_addr_o <= '0;
    end else begin
      gap <= (acc | ~load) ? '0 : gap + GW'(1);
      if (restart) k <= '0;
      else if (state == WRITE) k <= k + KW'(1);
      if ((state == LEN_HI) & acc) len <= KW'(n);
      if (word_full) mem_addr_o <= 32'(k) << 2;
    end

`ifdef LOADER_CHECKSUM_EN
  // running XOR of every data byte, compared against the trailing checksum byte
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) chk <= '0;
    else if (restart) chk <= '0;
    else if ((state == DATA) & acc) chk <= chk ^ byte_i;
`endif
endmodule
